// File: rtl/gp_pkg.sv
// Shared types for the generic-payload initiator: command/status encodings,
// the latched request record and the initiator state machine encoding.
package gp_pkg;

  localparam int GP_ADDR_W = 32;
  localparam int GP_DATA_W = 32;

  typedef enum logic [1:0] {
    GP_READ    = 2'd0,
    GP_WRITE   = 2'd1,
    GP_IGNORE  = 2'd2,
    GP_END_SIM = 2'd3
  } gp_cmd_e;

  typedef enum logic [2:0] {
    GP_OK                = 3'd0,
    GP_INCOMPLETE        = 3'd1,
    GP_GENERIC_ERROR     = 3'd2,
    GP_ADDRESS_ERROR     = 3'd3,
    GP_BYTE_ENABLE_ERROR = 3'd4
  } gp_status_e;

  typedef struct packed {
    gp_cmd_e                  cmd;
    logic [GP_ADDR_W-1:0]     addr;
    logic [GP_DATA_W-1:0]     data;
    logic [GP_DATA_W/8-1:0]   be;
  } gp_req_t;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ISSUE    = 3'd1,
    ST_WAIT_RSP = 3'd2,
    ST_RESPOND  = 3'd3,
    ST_DONE     = 3'd4
  } gp_state_e;

endpackage

// File: rtl/gp_timeout_ctr.sv
// Response watchdog: counts cycles while enabled, flags the last allowed cycle.
module gp_timeout_ctr #(
  parameter int TIMEOUT = 64
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt_d, cnt_q;

  assign expire_o = (cnt_q == CW'(TIMEOUT - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && !expire_o) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/gp_initiator.sv
// Generic-payload initiator: validates a client request, forwards it to the
// target, waits (bounded) for the response and returns status/data to the client.
module gp_initiator
  import gp_pkg::*;
#(
  parameter int ADDR_W   = GP_ADDR_W,
  parameter int DATA_W   = GP_DATA_W,
  parameter int ADDR_MAX = 255,
  parameter int TIMEOUT  = 64
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                req_valid_i,
  output logic                req_ready_o,
  input  logic [1:0]          req_cmd_i,
  input  logic [ADDR_W-1:0]   req_addr_i,
  input  logic [DATA_W-1:0]   req_data_i,
  input  logic [DATA_W/8-1:0] req_be_i,
  output logic                rsp_valid_o,
  input  logic                rsp_ready_i,
  output logic [2:0]          rsp_status_o,
  output logic [DATA_W-1:0]   rsp_data_o,
  output logic                tgt_valid_o,
  input  logic                tgt_ready_i,
  output logic [1:0]          tgt_cmd_o,
  output logic [ADDR_W-1:0]   tgt_addr_o,
  output logic [DATA_W-1:0]   tgt_data_o,
  output logic [DATA_W/8-1:0] tgt_be_o,
  input  logic                tgt_rsp_valid_i,
  input  logic [2:0]          tgt_rsp_status_i,
  input  logic [DATA_W-1:0]   tgt_rsp_data_i,
  output logic                end_sim_o,
  output logic                busy_o,
  output logic [15:0]         txn_cnt_o
);

  gp_state_e           state_d, state_q;
  gp_req_t             req_d, req_q;
  gp_status_e          rsp_status_d, rsp_status_q;
  logic [DATA_W-1:0]   rsp_data_d, rsp_data_q;
  logic [15:0]         txn_cnt_d, txn_cnt_q;
  logic                end_sim_d, end_sim_q;
  logic                req_ready_d, req_ready_q;
  logic                tgt_valid_d, tgt_valid_q;
  logic                rsp_valid_d, rsp_valid_q;
  logic                busy_d, busy_q;
  logic                tmo_expire;

  gp_timeout_ctr #(
    .TIMEOUT (TIMEOUT)
  ) u_tmo (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .clr_i    (state_q != ST_WAIT_RSP),
    .en_i     (state_q == ST_WAIT_RSP),
    .expire_o (tmo_expire)
  );

  always_comb begin
    state_d      = state_q;
    req_d        = req_q;
    rsp_status_d = rsp_status_q;
    rsp_data_d   = rsp_data_q;
    txn_cnt_d    = txn_cnt_q;
    end_sim_d    = end_sim_q;

    unique case (state_q)
      ST_IDLE: begin
        if (req_valid_i && req_ready_q) begin
          req_d.cmd  = gp_cmd_e'(req_cmd_i);
          req_d.addr = GP_ADDR_W'(req_addr_i);
          req_d.data = GP_DATA_W'(req_data_i);
          req_d.be   = (GP_DATA_W/8)'(req_be_i);
          rsp_data_d = '0;
          // Local checks in priority order; IGNORE succeeds even for a bad address
          if (gp_cmd_e'(req_cmd_i) == GP_IGNORE) begin
            rsp_status_d = GP_OK;
            state_d      = ST_RESPOND;
          end else if (req_addr_i > ADDR_W'(ADDR_MAX)) begin
            rsp_status_d = GP_ADDRESS_ERROR;
            state_d      = ST_RESPOND;
          end else if (gp_cmd_e'(req_cmd_i) == GP_WRITE && req_be_i == '0) begin
            rsp_status_d = GP_BYTE_ENABLE_ERROR;
            state_d      = ST_RESPOND;
          end else begin
            state_d = ST_ISSUE;
          end
        end
      end
      ST_ISSUE: begin
        if (tgt_ready_i) begin
          if (req_q.cmd == GP_END_SIM) begin
            end_sim_d = 1'b1;
            state_d   = ST_DONE;
          end else begin
            state_d = ST_WAIT_RSP;
          end
        end
      end
      ST_WAIT_RSP: begin
        if (tgt_rsp_valid_i) begin
          rsp_status_d = gp_status_e'(tgt_rsp_status_i);
          if (req_q.cmd == GP_READ && gp_status_e'(tgt_rsp_status_i) == GP_OK) begin
            rsp_data_d = tgt_rsp_data_i;
          end else begin
            rsp_data_d = '0;
          end
          state_d = ST_RESPOND;
        end else if (tmo_expire) begin
          rsp_status_d = GP_GENERIC_ERROR;
          rsp_data_d   = '0;
          state_d      = ST_RESPOND;
        end
      end
      ST_RESPOND: begin
        if (rsp_ready_i) begin
          if (txn_cnt_q != 16'hFFFF) begin
            txn_cnt_d = txn_cnt_q + 16'd1;
          end
          state_d = ST_IDLE;
        end
      end
      ST_DONE: begin
        state_d = ST_DONE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Handshake outputs are registered copies of the next state
    req_ready_d = (state_d == ST_IDLE);
    tgt_valid_d = (state_d == ST_ISSUE);
    rsp_valid_d = (state_d == ST_RESPOND);
    busy_d      = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= ST_IDLE;
      req_q        <= '0;
      rsp_status_q <= GP_OK;
      rsp_data_q   <= '0;
      txn_cnt_q    <= '0;
      end_sim_q    <= 1'b0;
      req_ready_q  <= 1'b0;
      tgt_valid_q  <= 1'b0;
      rsp_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      req_q        <= req_d;
      rsp_status_q <= rsp_status_d;
      rsp_data_q   <= rsp_data_d;
      txn_cnt_q    <= txn_cnt_d;
      end_sim_q    <= end_sim_d;
      req_ready_q  <= req_ready_d;
      tgt_valid_q  <= tgt_valid_d;
      rsp_valid_q  <= rsp_valid_d;
      busy_q       <= busy_d;
    end
  end

  assign req_ready_o  = req_ready_q;
  assign rsp_valid_o  = rsp_valid_q;
  assign rsp_status_o = rsp_status_q;
  assign rsp_data_o   = rsp_data_q;
  assign tgt_valid_o  = tgt_valid_q;
  assign tgt_cmd_o    = req_q.cmd;
  assign tgt_addr_o   = ADDR_W'(req_q.addr);
  assign tgt_data_o   = DATA_W'(req_q.data);
  assign tgt_be_o     = (DATA_W/8)'(req_q.be);
  assign end_sim_o    = end_sim_q;
  assign busy_o       = busy_q;
  assign txn_cnt_o    = txn_cnt_q;

endmodule

// File: tb/tb_gp_initiator.sv
// Directed bench for gp_initiator: expected client responses are queued by the
// stimulus and consumed by an independent response monitor.
module tb_gp_initiator;

  logic        clk;
  logic        rst_ni;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [1:0]  req_cmd_i;
  logic [31:0] req_addr_i;
  logic [31:0] req_data_i;
  logic [3:0]  req_be_i;
  logic        rsp_valid_o;
  logic        rsp_ready_i;
  logic [2:0]  rsp_status_o;
  logic [31:0] rsp_data_o;
  logic        tgt_valid_o;
  logic        tgt_ready_i;
  logic [1:0]  tgt_cmd_o;
  logic [31:0] tgt_addr_o;
  logic [31:0] tgt_data_o;
  logic [3:0]  tgt_be_o;
  logic        tgt_rsp_valid_i;
  logic [2:0]  tgt_rsp_status_i;
  logic [31:0] tgt_rsp_data_i;
  logic        end_sim_o;
  logic        busy_o;
  logic [15:0] txn_cnt_o;

  gp_initiator #(
    .ADDR_W(32), .DATA_W(32), .ADDR_MAX(255), .TIMEOUT(64)
  ) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_cmd_i(req_cmd_i), .req_addr_i(req_addr_i),
    .req_data_i(req_data_i), .req_be_i(req_be_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_status_o(rsp_status_o), .rsp_data_o(rsp_data_o),
    .tgt_valid_o(tgt_valid_o), .tgt_ready_i(tgt_ready_i),
    .tgt_cmd_o(tgt_cmd_o), .tgt_addr_o(tgt_addr_o),
    .tgt_data_o(tgt_data_o), .tgt_be_o(tgt_be_o),
    .tgt_rsp_valid_i(tgt_rsp_valid_i), .tgt_rsp_status_i(tgt_rsp_status_i),
    .tgt_rsp_data_i(tgt_rsp_data_i),
    .end_sim_o(end_sim_o), .busy_o(busy_o), .txn_cnt_o(txn_cnt_o)
  );

  localparam logic [1:0] C_READ = 2'd0, C_WRITE = 2'd1, C_IGNORE = 2'd2, C_END = 2'd3;
  localparam logic [2:0] S_OK = 3'd0, S_INC = 3'd1, S_GEN = 3'd2, S_ADDR = 3'd3, S_BE = 3'd4;

  typedef struct {
    logic [2:0]  st;
    logic [31:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask

  // Response monitor: a handshake completes at the next rising edge
  always @(negedge clk) begin
    if (rst_ni && rsp_valid_o && rsp_ready_i) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rsp got status %0h expected none", rsp_status_o);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("rsp_status", 64'(rsp_status_o), 64'(e.st));
        chk("rsp_data", 64'(rsp_data_o), 64'(e.data));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [2:0] st, input logic [31:0] data);
    exp_t e;
    e.st = st;
    e.data = data;
    exp_q.push_back(e);
  endtask

  // Returns one cycle after the accepting edge (cycle N+1)
  task automatic send_req(input logic [1:0] cmd, input logic [31:0] addr,
                          input logic [31:0] data, input logic [3:0] be);
    int n;
    n = 0;
    while (!req_ready_o && n < 50) begin
      tick();
      n++;
    end
    if (!req_ready_o) chk("req_ready_wait", 64'(req_ready_o), 64'd1);
    req_valid_i = 1'b1;
    req_cmd_i   = cmd;
    req_addr_i  = addr;
    req_data_i  = data;
    req_be_i    = be;
    tick();
    req_valid_i = 1'b0;
  endtask

  task automatic tgt_accept();
    tgt_ready_i = 1'b1;
    tick();
    tgt_ready_i = 1'b0;
  endtask

  task automatic tgt_respond(input logic [2:0] st, input logic [31:0] data);
    tgt_rsp_valid_i  = 1'b1;
    tgt_rsp_status_i = st;
    tgt_rsp_data_i   = data;
    tick();
    tgt_rsp_valid_i  = 1'b0;
    tgt_rsp_data_i   = 32'h0;
  endtask

  initial begin
    int n;
    rst_ni = 1'b0;
    req_valid_i = 1'b0; req_cmd_i = '0; req_addr_i = '0; req_data_i = '0; req_be_i = '0;
    rsp_ready_i = 1'b1; tgt_ready_i = 1'b0;
    tgt_rsp_valid_i = 1'b0; tgt_rsp_status_i = '0; tgt_rsp_data_i = '0;

    repeat (3) @(posedge clk);
    #1;
    chk("reset_req_ready", 64'(req_ready_o), 64'd0);
    chk("reset_busy", 64'(busy_o), 64'd0);
    chk("reset_txn_cnt", 64'(txn_cnt_o), 64'd0);
    chk("reset_outs", 64'({rsp_valid_o, tgt_valid_o, end_sim_o}), 64'd0);
    rst_ni = 1'b1;
    tick();
    chk("idle_req_ready", 64'(req_ready_o), 64'd1);

    // WRITE, target ready at once, response pulsed 3 cycles after acceptance
    push_exp(S_OK, 32'h0);
    send_req(C_WRITE, 32'd5, 32'hDEADBEEF, 4'hF);
    chk("wr_tgt_valid_n1", 64'(tgt_valid_o), 64'd1);
    chk("wr_tgt_fields", {tgt_cmd_o, tgt_be_o, tgt_addr_o[7:0], tgt_data_o},
        {2'd1, 4'hF, 8'd5, 32'hDEADBEEF});
    tgt_accept();
    chk("wr_busy", 64'(busy_o), 64'd1);
    tick();
    tick();
    tgt_respond(S_OK, 32'h12345678);
    chk("wr_rsp_valid_m1", 64'(rsp_valid_o), 64'd1);
    tick();
    chk("wr_txn_cnt", 64'(txn_cnt_o), 64'd1);

    // READ with client back-pressure for 4 cycles
    rsp_ready_i = 1'b0;
    push_exp(S_OK, 32'hDEADBEEF);
    send_req(C_READ, 32'd5, 32'h0, 4'h0);
    tgt_accept();
    tgt_respond(S_OK, 32'hDEADBEEF);
    for (int i = 0; i < 4; i++) begin
      chk("rd_hold", {rsp_valid_o, req_ready_o, rsp_status_o, rsp_data_o},
          {1'b1, 1'b0, S_OK, 32'hDEADBEEF});
      tick();
    end
    rsp_ready_i = 1'b1;
    tick();
    chk("rd_txn_cnt", 64'(txn_cnt_o), 64'd2);

    // Local errors: response at N+1, target never driven
    push_exp(S_ADDR, 32'h0);
    send_req(C_READ, 32'd256, 32'h0, 4'hF);
    chk("addr_err_tgt", {tgt_valid_o, rsp_valid_o}, 2'b01);
    tick();
    push_exp(S_BE, 32'h0);
    send_req(C_WRITE, 32'd3, 32'hA5A5A5A5, 4'h0);
    chk("be_err_tgt", {tgt_valid_o, rsp_valid_o}, 2'b01);
    tick();
    push_exp(S_OK, 32'h0);
    send_req(C_IGNORE, 32'd999, 32'h0, 4'h0);
    chk("ignore_tgt", {tgt_valid_o, rsp_valid_o}, 2'b01);
    tick();
    chk("local_txn_cnt", 64'(txn_cnt_o), 64'd5);

    // Silent target: generic error 64 cycles after entering WAIT_RSP
    push_exp(S_GEN, 32'h0);
    send_req(C_READ, 32'd7, 32'h0, 4'hF);
    tgt_accept();
    n = 0;
    while (!rsp_valid_o && n < 200) begin
      tick();
      n++;
    end
    chk("timeout_cycles", 64'(n), 64'd64);
    tick();

    // Target response on the last timeout cycle beats the timeout
    push_exp(S_OK, 32'hCAFEF00D);
    send_req(C_READ, 32'd8, 32'h0, 4'hF);
    tgt_accept();
    repeat (63) tick();
    chk("race_no_rsp_yet", 64'(rsp_valid_o), 64'd0);
    tgt_respond(S_OK, 32'hCAFEF00D);
    chk("race_rsp_valid", 64'(rsp_valid_o), 64'd1);
    tick();

    // Target stall: request fields hold steady
    send_req(C_WRITE, 32'd9, 32'h0BADF00D, 4'h3);
    for (int i = 0; i < 10; i++) begin
      chk("stall_hold", {tgt_valid_o, tgt_cmd_o, tgt_be_o, tgt_addr_o, tgt_data_o},
          {1'b1, 2'd1, 4'h3, 32'd9, 32'h0BADF00D});
      tick();
    end
    tgt_accept();
    tick();
    tick();
    // Asynchronous reset mid WAIT_RSP aborts the transaction
    rst_ni = 1'b0;
    #1;
    chk("rst_async_outs", {req_ready_o, rsp_valid_o, tgt_valid_o, end_sim_o, busy_o},
        5'b0);
    chk("rst_async_cnt", {16'h0, txn_cnt_o, tgt_addr_o}, 64'd0);
    tick();
    rst_ni = 1'b1;
    tick();
    push_exp(S_OK, 32'h00000055);
    send_req(C_READ, 32'd255, 32'h0, 4'hF);
    chk("post_rst_tgt_addr", {tgt_valid_o, tgt_addr_o}, {1'b1, 32'd255});
    tgt_accept();
    tgt_respond(S_OK, 32'h00000055);
    tick();
    chk("post_rst_txn_cnt", 64'(txn_cnt_o), 64'd1);

    // END_SIM: sticky flag, no further requests, no client response
    send_req(C_END, 32'd0, 32'h0, 4'h0);
    chk("end_tgt_valid", {tgt_valid_o, tgt_cmd_o}, {1'b1, 2'd3});
    tgt_accept();
    req_valid_i = 1'b1;
    req_cmd_i   = C_READ;
    for (int i = 0; i < 6; i++) begin
      chk("done_state", {end_sim_o, req_ready_o, tgt_valid_o, rsp_valid_o},
          4'b1000);
      tick();
    end
    req_valid_i = 1'b0;
    chk("done_txn_cnt", 64'(txn_cnt_o), 64'd1);
    chk("exp_q_empty", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
